// File: rtl/ahb_lite_slave_bridge.sv
// AHB-Lite slave bridge to a single peripheral register block: address-phase capture, waited data phase,
// byte-lane strobes and the two-cycle ERROR response. Define AHB_ALIGN_CHECK_EN to reject misaligned/oversized transfers.
module ahb_lite_slave_bridge #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] IDLE_ADDR = 'hF000_0000,
    parameter int                TIMEOUT   = 16
) (
    input  logic                HCLK,
    input  logic                HRESET,
    input  logic                HSEL,
    input  logic [ADDR_W-1:0]   HADDR,
    input  logic                HWRITE,
    input  logic [2:0]          HSIZE,
    input  logic [1:0]          HTRANS,
    input  logic [DATA_W-1:0]   HWDATA,
    input  logic                HREADY,
    output logic [DATA_W-1:0]   HRDATA,
    output logic                HREADYOUT,
    output logic                HRESP,
    output logic [ADDR_W-1:0]   per_addr,
    output logic                per_we,
    output logic                per_re,
    output logic [2:0]          per_size,
    output logic [DATA_W/8-1:0] per_wstrb,
    output logic [DATA_W-1:0]   per_wdata,
    input  logic [DATA_W-1:0]   per_rdata,
    input  logic                per_ready,
    input  logic                per_err
);

    localparam int NB    = DATA_W / 8;
    localparam int L     = $clog2(NB);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_ERR1, ST_ERR2} state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic                we_reg, we_next;
    logic [2:0]          size_reg, size_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [DATA_W-1:0]   hrdata_reg, hrdata_next;
    logic                valid, bad_xfer, accept, timeout_hit;
    logic [L-1:0]        lane_idx;
    logic [NB-1:0]       lane_hit;

    assign valid       = HSEL & HREADY & HTRANS[1];
    assign timeout_hit = (TIMEOUT != 0) && (cnt_reg == CNT_W'(TIMEOUT));

`ifdef AHB_ALIGN_CHECK_EN
    logic [L-1:0] align_mask;
    assign align_mask = ~({L{1'b1}} << HSIZE);
    assign bad_xfer   = (HSIZE > 3'(L)) || ((HADDR[L-1:0] & align_mask) != '0);
`else
    assign bad_xfer   = 1'b0;
`endif

    always_comb begin
        state_next  = state_reg;
        addr_next   = addr_reg;
        we_next     = we_reg;
        size_next   = size_reg;
        cnt_next    = '0;
        hrdata_next = hrdata_reg;
        HREADYOUT   = 1'b1;
        HRESP       = 1'b0;
        per_we      = 1'b0;
        per_re      = 1'b0;
        accept      = 1'b0;
        case (state_reg)
            ST_IDLE: accept = 1'b1;
            ST_ACCESS: begin
                if (timeout_hit) begin
                    // Peripheral never answered: withdraw the request and report ERROR.
                    HREADYOUT  = 1'b0;
                    state_next = ST_ERR1;
                end else begin
                    per_we    = we_reg;
                    per_re    = ~we_reg;
                    HREADYOUT = per_ready & ~per_err;
                    if (per_ready && per_err) begin
                        state_next = ST_ERR1;
                    end else if (per_ready) begin
                        accept = 1'b1;
                        if (!we_reg) hrdata_next = per_rdata;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
            end
            ST_ERR1: begin
                HREADYOUT  = 1'b0;
                HRESP      = 1'b1;
                state_next = ST_ERR2;
            end
            default: begin
                HRESP  = 1'b1;
                accept = 1'b1;
            end
        endcase
        // A new address phase can only complete on a cycle where this slave is ready.
        if (accept) begin
            state_next = ST_IDLE;
            if (valid) begin
                if (bad_xfer) begin
                    state_next = ST_ERR1;
                end else begin
                    state_next = ST_ACCESS;
                    addr_next  = HADDR;
                    we_next    = HWRITE;
                    size_next  = HSIZE;
                end
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_reg  <= ST_IDLE;
            addr_reg   <= IDLE_ADDR;
            we_reg     <= 1'b0;
            size_reg   <= 3'd0;
            cnt_reg    <= '0;
            hrdata_reg <= '0;
        end else begin
            state_reg  <= state_next;
            addr_reg   <= addr_next;
            we_reg     <= we_next;
            size_reg   <= size_next;
            cnt_reg    <= cnt_next;
            hrdata_reg <= hrdata_next;
        end
    end

    // A lane is enabled when it falls in the same 2**size block as the addressed byte.
    assign lane_idx = addr_reg[L-1:0];
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane
            localparam logic [L-1:0] LANE = L'(gi);
            assign lane_hit[gi] = (size_reg >= 3'(L)) || ((LANE >> size_reg) == (lane_idx >> size_reg));
        end
    endgenerate

    assign per_wstrb = per_we ? lane_hit : '0;
    assign per_addr  = (state_reg == ST_ACCESS) ? addr_reg : IDLE_ADDR;
    assign per_size  = size_reg;
    assign per_wdata = HWDATA;
    assign HRDATA    = hrdata_next;

endmodule
